// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one subtract cell plus a borrow flop.
// Optional signed-overflow output `ovf` enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             ai, bi, dbit, nbr, last;

  assign ai   = a_sr[0];
  assign bi   = b_sr[0];
  assign dbit = ai ^ bi ^ br;
  assign nbr  = (~ai & bi) | (~ai & br) | (bi & br);
  assign last = (cnt == CW'(WIDTH - 1));

`ifdef SUB_OVERFLOW_EN
  // Operand sign bits survive the shift so overflow can be judged at the end.
  logic a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (start) begin
                 a_msb <= a[WIDTH-1];
                 b_msb <= b[WIDTH-1];
                 ovf   <= 1'b0;
               end
        SHIFT: if (last) ovf <= (a_msb != b_msb) && (dbit != a_msb);
        default: ;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          br    <= bin;
          cnt   <= '0;
          diff  <= '0;
          bout  <= 1'b0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= nbr;
          diff <= {dbit, diff[WIDTH-1:1]};
          if (last) begin
            bout  <= nbr;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;
  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s4 = 1'b0, bin4 = 1'b0, s8 = 1'b0, bin8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       busy4, done4, bout4, busy8, done8, bout8;
`ifdef SUB_OVERFLOW_EN
  logic       ovf4, ovf8;
`endif

  exp_t q4[$], q8[$];
  int   nchk = 0, npass = 0, ndone4 = 0, ndone8 = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bi);
    exp_t e;
    int full, sa, sb, sr;
    full = int'(a) - int'(b) - int'(bi);
    e.d  = 8'(full & ((1 << w) - 1));
    e.bo = (full < 0);
    sa   = a[w-1] ? int'(a) - (1 << w) : int'(a);
    sb   = b[w-1] ? int'(b) - (1 << w) : int'(b);
    sr   = sa - sb - int'(bi);
    e.ov = (sr > (1 << (w-1)) - 1) || (sr < -(1 << (w-1)));
    return e;
  endfunction

  always @(negedge clk) if (rst_n && done4) begin
    exp_t e;
    ndone4++;
    if (q4.size() == 0) chk("unexp_done4", 1, 0);
    else begin
      e = q4.pop_front();
      chk("diff4", 32'(diff4), 32'(e.d[3:0]));
      chk("bout4", 32'(bout4), 32'(e.bo));
`ifdef SUB_OVERFLOW_EN
      chk("ovf4", 32'(ovf4), 32'(e.ov));
`endif
    end
  end

  always @(negedge clk) if (rst_n && done8) begin
    exp_t e;
    ndone8++;
    if (q8.size() == 0) chk("unexp_done8", 1, 0);
    else begin
      e = q8.pop_front();
      chk("diff8", 32'(diff8), 32'(e.d));
      chk("bout8", 32'(bout8), 32'(e.bo));
`ifdef SUB_OVERFLOW_EN
      chk("ovf8", 32'(ovf8), 32'(e.ov));
`endif
    end
  end

  // Presents one request for exactly one accepting edge; returns #1 after it.
  task automatic go4(input logic [3:0] aa, input logic [3:0] bb, input logic bi, input bit push);
    s4 = 1'b1; a4 = aa; b4 = bb; bin4 = bi;
    if (push) q4.push_back(model(4, 8'(aa), 8'(bb), bi));
    @(posedge clk); #1;
    s4 = 1'b0;
  endtask

  task automatic go8(input logic [7:0] aa, input logic [7:0] bb, input logic bi);
    s8 = 1'b1; a8 = aa; b8 = bb; bin8 = bi;
    q8.push_back(model(8, aa, bb, bi));
    @(posedge clk); #1;
    s8 = 1'b0;
  endtask

  task automatic wait_done4();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4) return;
    end
    chk("timeout4", 0, 1);
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) return;
    end
    chk("timeout8", 0, 1);
  endtask

  // One full operation, then step back into IDLE.
  task automatic op4(input logic [3:0] aa, input logic [3:0] bb, input logic bi);
    go4(aa, bb, bi, 1'b1);
    wait_done4();
    @(posedge clk); #1;
  endtask

  task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic bi);
    go8(aa, bb, bi);
    wait_done8();
    @(posedge clk); #1;
  endtask

  initial begin
    int done_k, nbusy, snap, cyc, nrise, rises[3];
    logic pb;

    repeat (3) @(posedge clk);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_diff", 32'(diff4), 0);
    chk("rst_bout", 32'(bout4), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic op with latency / busy-length measurement.
    go4(4'd9, 4'd3, 1'b0, 1'b1);
    done_k = 0; nbusy = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (busy4) nbusy++;
      if (done4 && done_k == 0) done_k = k;
    end
    chk("lat_done", 32'(done_k), 5);
    chk("busy_cyc", 32'(nbusy), 5);

    op4(4'd3, 4'd9, 1'b0);
    op4(4'd0, 4'd0, 1'b1);

    // start/operands changing while busy, and start pulsed during DONE.
    snap = ndone4;
    go4(4'd5, 4'd2, 1'b0, 1'b1);
    @(posedge clk); #1;
    s4 = 1'b1; a4 = 4'hf; b4 = 4'hf; bin4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0; a4 = 4'h1;
    wait_done4();
    s4 = 1'b1; a4 = 4'h2; b4 = 4'h7;
    @(posedge clk); #1;
    s4 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("one_done", 32'(ndone4 - snap), 1);
    chk("idle_after", 32'(busy4), 0);

    // Reset two SHIFT edges into an operation.
    snap = ndone4;
    go4(4'hf, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_done", 32'(done4), 0);
    chk("abort_diff", 32'(diff4), 0);
    chk("abort_bout", 32'(bout4), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_nodone", 32'(ndone4 - snap), 0);
    op4(4'hf, 4'h1, 1'b0);

    // Signed overflow corners (checked only when the port exists).
    op4(4'h7, 4'hf, 1'b0);
    op4(4'h8, 4'h1, 1'b0);
    op4(4'h5, 4'h2, 1'b0);

    // start held high: accepts should be WIDTH+2 cycles apart.
    s4 = 1'b1; a4 = 4'hc; b4 = 4'h5; bin4 = 1'b1;
    repeat (3) q4.push_back(model(4, 8'hc, 8'h5, 1'b1));
    nrise = 0; pb = busy4; cyc = 0;
    while (nrise < 3 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (busy4 && !pb) begin rises[nrise] = cyc; nrise++; end
      pb = busy4;
    end
    @(posedge clk); #1;
    s4 = 1'b0;
    chk("b2b_count", 32'(nrise), 3);
    if (nrise == 3) begin
      chk("b2b_gap1", 32'(rises[1] - rises[0]), 6);
      chk("b2b_gap2", 32'(rises[2] - rises[1]), 6);
    end
    cyc = 0;
    while ((q4.size() != 0 || busy4) && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("b2b_drain", 32'(q4.size()), 0);

    // Random operands at both widths concurrently.
    fork
      for (int i = 0; i < 1000; i++)
        op4(4'($urandom), 4'($urandom), 1'($urandom));
      for (int i = 0; i < 1000; i++)
        op8(8'($urandom), 8'($urandom), 1'($urandom));
    join
    repeat (3) @(posedge clk);
    chk("q4_empty", 32'(q4.size()), 0);
    chk("q8_empty", 32'(q8.size()), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing `a - b - bin` one bit per clock, LSB first, using a single subtract cell and a borrow flop. It is the inverse-operation counterpart to the team's ripple-carry adder. It trades latency for area in datapaths where one result per WIDTH+2 cycles is sufficient. Operands are captured on a start handshake and the result is announced with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend; captured on the accepting edge.
- `bin`  in  1  borrow in; captured on the accepting edge.
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse; the result is valid.
- `diff`  out  WIDTH  result `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  borrow out; 1 iff `a < b + bin`, unsigned.
- `ovf`  out  1  signed overflow; present only with `SUB_OVERFLOW_EN`.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:** when `start`=1 at an edge, load `a`, `b` into shift registers. Set the borrow flop to `bin`, clear the bit counter, and go to SHIFT.
- **SHIFT:** each edge processes bit i (i = 0..WIDTH-1).
  - Difference bit: `a_i ^ b_i ^ br`.
  - Next borrow: `(~a_i & b_i) | (~a_i & br) | (b_i & br)`.
  - The difference bit shifts into `diff` from the MSB side, so after WIDTH edges bit 0 sits at `diff[0]`.
- **SHIFT exit:** after the edge processing bit WIDTH-1, register `bout` as the final borrow and go to DONE.
- **DONE:** `done`=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- **`start` outside IDLE:** ignored, including in DONE. No queuing, no error.
- **`a`/`b`/`bin` outside the accepting edge:** changes have no effect.
- **`diff`/`bout` hold:** hold their values from DONE until the next accepting edge. On the accepting edge `diff` clears to 0 and `bout` to 0, so partial results are never presented as valid.
- **Counter:** width `$clog2(WIDTH)+1`, with no wrap-around in any state.

## Timing
- **Reset:** asserting `rst_n`=0 at any time, including mid-SHIFT, asynchronously forces:
  - state IDLE
  - `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0
  - internal shift registers, borrow and counter to 0
- **Aborted operation:** an operation interrupted by reset never produces `done`. After release, the first edge with `start`=1 is accepted.
- **Latency:** with `start` accepted at edge E0:
  - `busy` goes high after E0.
  - Bits are processed at edges E1..E_WIDTH.
  - `done` is high in the cycle after edge E_WIDTH.
  - `busy` drops after edge E_WIDTH+1.
- **Throughput:** one operation per WIDTH+2 cycles. `start` held high continuously gives back-to-back operations with one IDLE cycle between them.
- **Registered outputs:** `done`, `busy`, `diff`, `bout` and `ovf` are all registered. There is no combinational path from inputs to outputs.

## Configuration
- **Macro `SUB_OVERFLOW_EN`.**
- **Defined:**
  - Port `ovf` exists. The MSB of the captured `a` and `b` is retained.
  - `ovf` is registered at the SHIFT→DONE edge as `(a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])`, i.e. two's-complement overflow of `a - b - bin`.
  - `ovf` holds and clears exactly like `bout`.
- **Undefined:** no `ovf` port and no extra flops. All other behaviour is identical.

## Test plan
- **Basic, no borrow:** WIDTH=4, a=9, b=3, bin=0, `start` for 1 cycle → `done` in the 5th cycle after the accepting edge, diff=6, bout=0, busy high 5 cycles.
- **Borrow and carry-in:**
  - a=3, b=9, bin=0 → diff=0xA, bout=1.
  - a=0, b=0, bin=1 → diff=0xF, bout=1.
- **Start ignored while busy:** pulse `start` with new operands 2 cycles after acceptance and again while `done`=1 → only one `done`; result matches the first operands. `a` changed mid-SHIFT has no effect.
- **Reset mid-operation:** drop `rst_n` after 2 SHIFT edges → all outputs 0 immediately and no `done`. After release, a=15, b=1 → diff=14, bout=0.
- **Overflow (`SUB_OVERFLOW_EN`):**
  - a=0x7, b=0xF → diff=0x8, ovf=1, bout=1.
  - a=0x8, b=0x1 → diff=0x7, ovf=1, bout=0.
  - a=5, b=2 → ovf=0.
- **Back-to-back and random:** `start` held high for 3 operations → accepting edges 6 cycles apart. Then 1000 random operands at WIDTH=4 and WIDTH=8 → `diff`/`bout` match a reference `a - b - bin` model.
